// File: rtl/mux_check_pkg.sv
// rtl/mux_check_pkg.sv - shared state encoding and constants for the mux checker
package mux_check_pkg;

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] NO_ERR_IDX = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/delay_line.sv
// rtl/delay_line.sv - resettable DEPTH-stage shift register; DEPTH=0 passes din straight through
module delay_line #(
  parameter int DEPTH = 0,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  // At least one stage is always declared so the DEPTH=0 case stays legal; it is simply unused.
  localparam int N = (DEPTH == 0) ? 1 : DEPTH;

  logic [WIDTH-1:0] sr [N];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) sr[i] <= '0;
    end else begin
      sr[0] <= din;
      for (int i = 1; i < N; i++) sr[i] <= sr[i-1];
    end
  end

  assign dout = (DEPTH == 0) ? din : sr[N-1];

endmodule

// File: rtl/mux_checker.sv
// rtl/mux_checker.sv - compares an observed 2:1 mux output against sel ? b : a over a fixed-length run
module mux_checker
  import mux_check_pkg::*;
#(
  parameter int LAT        = 0,
  parameter int NUM_CHECKS = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             a,
  input  logic             b,
  input  logic             sel,
  input  logic             out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] chk_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] first_err
);

  state_t           state, state_nx;
  logic [CNT_W-1:0] issue_cnt;
  logic [1:0]       drain_cnt;
  logic             start_q;
  logic             exp_val, smp_valid;
  logic             d_exp, d_valid;
  logic             accept, mismatch;
  logic [CNT_W-1:0] err_nx;

  assign exp_val   = sel ? b : a;
  assign smp_valid = (state == RUN);

  delay_line #(.DEPTH(LAT), .WIDTH(2)) u_dly (
    .clk  (clk),
    .rst  (rst),
    .din  ({smp_valid, exp_val}),
    .dout ({d_valid, d_exp})
  );

  // Only a rising edge of start opens a run, so a held-high start yields a single run.
  assign accept   = start & ~start_q;
  assign mismatch = d_valid & (out != d_exp);
  assign err_nx   = mismatch ? sat_inc(err_cnt) : err_cnt;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN:     if (issue_cnt == CNT_W'(NUM_CHECKS - 1)) state_nx = (LAT == 0) ? DONE : DRAIN;
      DRAIN:   if (drain_cnt == 2'(LAT - 1)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state == RUN) || (state == DRAIN);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      start_q   <= 1'b0;
      issue_cnt <= '0;
      drain_cnt <= '0;
      chk_cnt   <= '0;
      err_cnt   <= '0;
      first_err <= NO_ERR_IDX;
      pass      <= 1'b0;
    end else begin
      state     <= state_nx;
      start_q   <= start;
      issue_cnt <= (state == RUN) ? issue_cnt + 1'b1 : '0;
      drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;
      if (state == IDLE && accept) begin
        chk_cnt   <= '0;
        err_cnt   <= '0;
        first_err <= NO_ERR_IDX;
        pass      <= 1'b0;
      end else if (d_valid) begin
        chk_cnt <= chk_cnt + 1'b1;
        err_cnt <= err_nx;
        if (mismatch && first_err == NO_ERR_IDX) first_err <= chk_cnt;
      end
      // err_nx folds in a mismatch seen on the very cycle the run ends.
      if (state_nx == DONE) pass <= (err_nx == '0);
    end
  end

endmodule

// File: tb/tb_mux_checker.sv
// tb/tb_mux_checker.sv - scoreboard bench driving three checker instances (LAT 0, 1, 2)
module tb_mux_checker;

  typedef struct {
    logic [7:0] chk;
    logic [7:0] err;
    logic [7:0] ferr;
    logic       pass;
    int         blen;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] start_v = 3'b000;
  logic a = 1'b0, b = 1'b0, sel = 1'b0, inj = 1'b0;
  logic out0, out1, out2;
  logic d1 = 1'b0, d2 = 1'b0;
  logic [2:0] busy_v, done_v, pass_v;
  logic [7:0] chk_v [3];
  logic [7:0] err_v [3];
  logic [7:0] ferr_v [3];

  int checks = 0;
  int errors = 0;
  int dones [3] = '{0, 0, 0};
  int blen [3] = '{0, 0, 0};
  exp_t q [3][$];
  exp_t me;

  // {a, b, sel}; set 0 gives expected 0,1,0,1,0 and set 1 gives 1,1,1,0,0
  logic [2:0] vec [2][5] = '{'{3'b010, 3'b011, 3'b101, 3'b100, 3'b001},
                             '{3'b100, 3'b111, 3'b011, 3'b000, 3'b101}};

  always #5 clk = ~clk;

  // Observed mux models: correct with optional fault, correct, and two-register delayed
  assign out0 = (sel ? b : a) ^ inj;
  assign out1 = sel ? b : a;
  always @(posedge clk) begin
    d1 <= sel ? b : a;
    d2 <= d1;
  end
  assign out2 = d2;

  mux_checker #(.LAT(0), .NUM_CHECKS(5)) u0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .a(a), .b(b), .sel(sel), .out(out0),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
    .chk_cnt(chk_v[0]), .err_cnt(err_v[0]), .first_err(ferr_v[0]));

  mux_checker #(.LAT(1), .NUM_CHECKS(5)) u1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .a(a), .b(b), .sel(sel), .out(out1),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
    .chk_cnt(chk_v[1]), .err_cnt(err_v[1]), .first_err(ferr_v[1]));

  mux_checker #(.LAT(2), .NUM_CHECKS(5)) u2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .a(a), .b(b), .sel(sel), .out(out2),
    .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]),
    .chk_cnt(chk_v[2]), .err_cnt(err_v[2]), .first_err(ferr_v[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int w, input logic [7:0] c, input logic [7:0] e,
                      input logic [7:0] f, input logic p, input int bl);
    exp_t x;
    x.chk = c; x.err = e; x.ferr = f; x.pass = p; x.blen = bl;
    q[w].push_back(x);
  endtask

  task automatic drive(input int set, input int i, input logic injv);
    {a, b, sel} = vec[set][i];
    inj = injv;
  endtask

  task automatic run(input int w, input int set, input logic [4:0] injm, input bit chk_first);
    @(posedge clk); #1 start_v[w] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1 start_v[w] = 1'b0;
      drive(set, i, injm[i]);
      if (i == 0 && chk_first) begin
        @(negedge clk);
        check($sformatf("run_first_chk_u%0d", w), 32'(chk_v[w]), 32'd0);
        check($sformatf("run_first_busy_u%0d", w), 32'(busy_v[w]), 32'd1);
      end
    end
  endtask

  task automatic wait_done(input int w);
    int n = 0;
    bit seen = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (done_v[w]) seen = 1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout_u%0d got no done expected done within 40 cycles", w);
    end
    @(posedge clk); #1 inj = 1'b0;
  endtask

  // Monitor: each done pulse pops the scoreboard and checks the run result
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) blen[i] = 0;
      else if (busy_v[i]) blen[i]++;
      if (done_v[i]) begin
        dones[i]++;
        if (q[i].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done_u%0d got done expected none", i);
        end else begin
          me = q[i].pop_front();
          check($sformatf("chk_cnt_u%0d", i), 32'(chk_v[i]), 32'(me.chk));
          check($sformatf("err_cnt_u%0d", i), 32'(err_v[i]), 32'(me.err));
          check($sformatf("first_err_u%0d", i), 32'(ferr_v[i]), 32'(me.ferr));
          check($sformatf("pass_u%0d", i), 32'(pass_v[i]), 32'(me.pass));
          check($sformatf("busy_len_u%0d", i), 32'(blen[i]), 32'(me.blen));
        end
        blen[i] = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int d0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy_u0", 32'(busy_v[0]), 32'd0);
    check("rst_done_u0", 32'(done_v[0]), 32'd0);
    check("rst_pass_u0", 32'(pass_v[0]), 32'd0);
    check("rst_chk_u0", 32'(chk_v[0]), 32'd0);
    check("rst_err_u0", 32'(err_v[0]), 32'd0);
    check("rst_ferr_u0", 32'(ferr_v[0]), 32'hFF);
    check("rst_ferr_u1", 32'(ferr_v[1]), 32'hFF);
    check("rst_busy_u2", 32'(busy_v[2]), 32'd0);

    // LAT=0 clean run
    push(0, 8'd5, 8'd0, 8'hFF, 1'b1, 5);
    run(0, 0, 5'b00000, 1'b1);
    wait_done(0);

    // LAT=0 with sample 2 inverted
    push(0, 8'd5, 8'd1, 8'd2, 1'b0, 5);
    run(0, 0, 5'b00100, 1'b0);
    wait_done(0);

    // LAT=2 against a two-register delayed mux
    push(2, 8'd5, 8'd0, 8'hFF, 1'b1, 7);
    run(2, 1, 5'b00000, 1'b0);
    wait_done(2);

    // LAT=1 against an undelayed mux, alternating expectations
    push(1, 8'd5, 8'd4, 8'd0, 1'b0, 6);
    run(1, 0, 5'b00000, 1'b0);
    wait_done(1);

    // Reset in RUN cycle 3 aborts the run (with one error already counted)
    @(posedge clk); #1 start_v[0] = 1'b1;
    @(posedge clk); #1 start_v[0] = 1'b0; drive(1, 0, 1'b0);
    @(posedge clk); #1 drive(1, 1, 1'b1);
    @(posedge clk); #1 drive(1, 2, 1'b0); rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy_v[0]), 32'd0);
    check("abort_done", 32'(done_v[0]), 32'd0);
    check("abort_chk", 32'(chk_v[0]), 32'd0);
    check("abort_err", 32'(err_v[0]), 32'd0);
    check("abort_ferr", 32'(ferr_v[0]), 32'hFF);
    repeat (6) @(posedge clk);
    push(0, 8'd5, 8'd0, 8'hFF, 1'b1, 5);
    run(0, 1, 5'b00000, 1'b0);
    wait_done(0);

    // start held high for 10 cycles: exactly one run
    push(0, 8'd5, 8'd0, 8'hFF, 1'b1, 5);
    d0 = dones[0];
    @(posedge clk); #1 start_v[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (i < 5) drive(0, i, 1'b0);
    end
    start_v[0] = 1'b0;
    repeat (8) @(posedge clk);
    check("held_start_dones", 32'(dones[0] - d0), 32'd1);

    // A fresh start after DONE restarts the counters
    push(0, 8'd5, 8'd0, 8'hFF, 1'b1, 5);
    run(0, 1, 5'b00000, 1'b1);
    wait_done(0);

    repeat (4) @(posedge clk);
    for (int i = 0; i < 3; i++)
      check($sformatf("scoreboard_left_u%0d", i), 32'(q[i].size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_checker.md
MUX_CHECKER -- requirements
Module: mux_checker

Interface
REQ-001 Parameter LAT, default 0, meaning DUT output latency in clock cycles, legal range 0..3.
REQ-002 Parameter NUM_CHECKS, default 5, meaning samples compared per run, legal range 1..255.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port start  input  1  single-cycle request to begin a run.
REQ-006 Port a, b, sel  input  1 each  stimulus as applied to the 2:1 mux under check.
REQ-007 Port out  input  1  mux output as observed.
REQ-008 Port busy  output  1  high while a run is in progress.
REQ-009 Port done  output  1  single-cycle pulse at run completion.
REQ-010 Port pass  output  1  high when the last completed run had zero mismatches.
REQ-011 Port chk_cnt  output  8  comparisons performed in the current or last run.
REQ-012 Port err_cnt  output  8  mismatches in the current or last run, saturating at 255.
REQ-013 Port first_err  output  8  sample index (0-based) of first mismatch; 8'hFF if none.

Function
REQ-014 Expected value per sample SHALL be sel ? b : a, computed combinationally from the current inputs.
REQ-015 Expected value and a sample-valid bit SHALL pass through an LAT-stage shift register; with LAT=0, the comparison uses the same-cycle out.
REQ-016 FSM states SHALL be IDLE, RUN, DRAIN, DONE.
REQ-017 IDLE: start=1 -> RUN next cycle; chk_cnt, err_cnt, first_err cleared to 0, 0, 8'hFF on that edge.
REQ-018 RUN: one sample enters the pipeline per cycle; after NUM_CHECKS samples are issued -> DRAIN.
REQ-019 DRAIN: no new samples are issued; remains for LAT cycles (zero cycles when LAT=0) -> DONE.
REQ-020 Compare: each cycle where the delayed valid bit=1, chk_cnt increments; on out != delayed expected, err_cnt increments (saturating) and first_err loads chk_cnt's pre-increment value if still 8'hFF.
REQ-021 DONE: lasts one cycle; done=1; pass loaded with (err_cnt==0 including any final-cycle mismatch); -> IDLE.
REQ-022 busy SHALL be 1 in RUN and DRAIN, 0 in IDLE and DONE.
REQ-023 start while busy or in DONE SHALL be ignored.
REQ-024 Counters and pass SHALL hold their values in IDLE until the next accepted start.
REQ-025 chk_cnt SHALL equal NUM_CHECKS when done pulses.

Reset
REQ-026 rst=1 at a clock edge SHALL force IDLE, busy=0, done=0, pass=0, chk_cnt=0, err_cnt=0, first_err=8'hFF, and clear all pipeline valid bits.
REQ-027 rst asserted mid-run SHALL abort the run with no done pulse; the next start begins a fresh run.

Structure
REQ-028 State encoding and constants NO_ERR_IDX=8'hFF and CNT_W=8 SHALL live in shared package mux_check_pkg.
REQ-029 The expected-value delay line SHALL be a sub-module, delay_line, parameterised by depth (0 = pass-through) and width.
REQ-030 The FSM and counters SHALL remain in mux_checker; no other sub-modules.

Verification
REQ-031 LAT=0, NUM_CHECKS=5, correct mux model, random a/b/sel -> done after 5 RUN cycles; pass=1, chk_cnt=5, err_cnt=0, first_err=8'hFF.
REQ-032 LAT=0, out forced inverted on sample 2 only -> err_cnt=1, first_err=2, pass=0.
REQ-033 LAT=2, DUT modelled with two-register delay -> busy high for 7 cycles, pass=1, chk_cnt=5.
REQ-034 LAT=1, DUT modelled with no delay, alternating expected values -> err_cnt>0, pass=0.
REQ-035 rst pulsed in cycle 3 of RUN -> busy=0 next cycle, no done pulse; counters cleared; subsequent start runs to pass=1.
REQ-036 start held high for 10 cycles -> exactly one run and one done pulse; second start after DONE accepted and counters restart at 0.
